// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_LAT_W = 4;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        FWAIT  = 3'd1,
        DATA   = 3'd2,
        DWAIT  = 3'd3,
        ENABLE = 3'd4,
        HALT   = 3'd5
    } mem_arb_state_t;

    localparam mem_arb_state_t MEM_ARB_RESET_STATE = FETCH;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Loadable down-counter that times the memory read latency; done is high while the count is zero.
module mem_arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [MEM_ARB_LAT_W-1:0] load_value,
    output logic                     done
);

    logic [MEM_ARB_LAT_W-1:0] count_q;
    logic [MEM_ARB_LAT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences instruction fetch and optional data access of a Harvard CPU onto one memory port.
// Optional stall counter enabled by defining MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           active,
    input  logic [31:0]    instr_address,
    output logic [31:0]    instr_readdata,
    input  logic [31:0]    data_address,
    input  logic [31:0]    data_writedata,
    input  logic           data_read,
    input  logic           data_write,
    output logic [31:0]    data_readdata,
    output logic           cpu_enable,
    output logic [31:0]    mem_address,
    output logic [31:0]    mem_writedata,
    output logic           mem_read,
    output logic           mem_write,
    input  logic [31:0]    mem_readdata,
    output logic [31:0]    stall_count,
    output mem_arb_state_t dbg_state
);

    localparam logic [MEM_ARB_LAT_W-1:0] LAT_M1 = MEM_ARB_LAT_W'(MEM_LATENCY - 1);

    // Handshake: mem_read/mem_write are one-cycle strobes with no backpressure;
    // read data is taken exactly MEM_LATENCY cycles after the strobe cycle.
    mem_arb_state_t state_q, state_d;
    logic           cpu_enable_q, cpu_enable_d;
    logic           mem_read_q, mem_read_d;
    logic           mem_write_q, mem_write_d;
    logic [31:0]    mem_address_q, mem_address_d;
    logic [31:0]    mem_writedata_q, mem_writedata_d;
    logic [31:0]    instr_rdata_q, instr_rdata_d;
    logic [31:0]    data_rdata_q, data_rdata_d;
    logic           wait_load;
    logic           wait_done;
    logic           to_fetch;
    logic           to_data;

    assign wait_load = ((state_q == FETCH) && mem_read_q) || (state_q == DATA);

    mem_arb_wait_counter u_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (wait_load),
        .load_value (LAT_M1),
        .done       (wait_done)
    );

    // FETCH with no strobe registered is the first cycle out of reset: issue the fetch there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_read_q) begin
                    state_d = FWAIT;
                end else if (!active) begin
                    state_d = HALT;
                end
            end
            FWAIT: begin
                if (wait_done) begin
                    state_d = (data_read || data_write) ? DATA : ENABLE;
                end
            end
            DATA:    state_d = mem_write_q ? ENABLE : DWAIT;
            DWAIT: begin
                if (wait_done) begin
                    state_d = ENABLE;
                end
            end
            ENABLE:  state_d = active ? FETCH : HALT;
            HALT:    state_d = HALT;
            default: state_d = MEM_ARB_RESET_STATE;
        endcase
    end

    always_comb begin
        to_fetch        = (state_d == FETCH);
        to_data         = (state_d == DATA);
        mem_read_d      = to_fetch || (to_data && !data_write);
        mem_write_d     = to_data && data_write;
        mem_address_d   = '0;
        mem_writedata_d = '0;
        if (to_fetch) begin
            mem_address_d = instr_address;
        end else if (to_data) begin
            mem_address_d = data_address;
        end
        if (mem_write_d) begin
            mem_writedata_d = data_writedata;
        end
        cpu_enable_d  = (state_d == ENABLE);
        instr_rdata_d = ((state_q == FWAIT) && wait_done) ? mem_readdata : instr_rdata_q;
        data_rdata_d  = ((state_q == DWAIT) && wait_done) ? mem_readdata : data_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= MEM_ARB_RESET_STATE;
            cpu_enable_q    <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            instr_rdata_q   <= '0;
            data_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            cpu_enable_q    <= cpu_enable_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            instr_rdata_q   <= instr_rdata_d;
            data_rdata_q    <= data_rdata_d;
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] stall_q;
    logic        stall_en;

    // The post-reset FETCH cycle before the first strobe is not a stall.
    assign stall_en = !cpu_enable_q && (state_q != HALT) && !((state_q == FETCH) && !mem_read_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (stall_en) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

    assign instr_readdata = instr_rdata_q;
    assign data_readdata  = data_rdata_q;
    assign cpu_enable     = cpu_enable_q;
    assign mem_address    = mem_address_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT at latency 1 (index 0) and one at latency 3 (index 1).
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_PORT_ARBITER_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active = 1'b1;
    logic [31:0] instr_address = 32'h0;
    logic [31:0] data_address = 32'h0;
    logic [31:0] data_writedata = 32'h0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;

    logic [31:0]    instr_rd [2];
    logic [31:0]    data_rd  [2];
    logic           cpu_en   [2];
    logic [31:0]    m_addr   [2];
    logic [31:0]    m_wdata  [2];
    logic           m_rd     [2];
    logic           m_wr     [2];
    logic [31:0]    m_rdata  [2];
    logic [31:0]    stall    [2];
    mem_arb_state_t dbg      [2];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h1234_5678;
            32'hFFFF_0008: return 32'hCAFE_F00D;
            default:       return ~a;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] pd [LAT];
        logic        pv [LAT];

        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < LAT; i++) begin
                    pv[i] <= 1'b0;
                    pd[i] <= 32'h0;
                end
            end else begin
                pv[0] <= m_rd[g];
                pd[0] <= mem_word(m_addr[g]);
                for (int i = 1; i < LAT; i++) begin
                    pv[i] <= pv[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end

        assign m_rdata[g] = pv[LAT-1] ? pd[LAT-1] : 32'h0BAD_F00D;

        mem_port_arbiter #(.MEM_LATENCY(LAT)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .active         (active),
            .instr_address  (instr_address),
            .instr_readdata (instr_rd[g]),
            .data_address   (data_address),
            .data_writedata (data_writedata),
            .data_read      (data_read),
            .data_write     (data_write),
            .data_readdata  (data_rd[g]),
            .cpu_enable     (cpu_en[g]),
            .mem_address    (m_addr[g]),
            .mem_writedata  (m_wdata[g]),
            .mem_read       (m_rd[g]),
            .mem_write      (m_wr[g]),
            .mem_readdata   (m_rdata[g]),
            .stall_count    (stall[g]),
            .dbg_state      (dbg[g])
        );
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_pulse(input int idx, input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!cpu_en[idx] && cycles < budget);
        if (!cpu_en[idx]) cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr_address = 32'h4;
        tick();
        tick();
        n_checks++; if (cpu_en[0] !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_enable got %0b exp 0", cpu_en[0]); end
        n_checks++; if (m_rd[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %0b exp 0", m_rd[0]); end
        n_checks++; if (m_wr[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %0b exp 0", m_wr[0]); end
        n_checks++; if (m_addr[0] !== 32'h0) begin n_fail++; $display("FAIL reset_mem_address got %h exp 0", m_addr[0]); end
        n_checks++; if (m_wdata[0] !== 32'h0) begin n_fail++; $display("FAIL reset_mem_writedata got %h exp 0", m_wdata[0]); end
        n_checks++; if (instr_rd[0] !== 32'h0) begin n_fail++; $display("FAIL reset_instr_readdata got %h exp 0", instr_rd[0]); end
        n_checks++; if (data_rd[0] !== 32'h0) begin n_fail++; $display("FAIL reset_data_readdata got %h exp 0", data_rd[0]); end
        n_checks++; if (stall[0] !== 32'h0) begin n_fail++; $display("FAIL reset_stall_count got %0d exp 0", stall[0]); end
        n_checks++; if (dbg[0] !== FETCH) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dbg[0], FETCH); end
    endtask

    task automatic test_fetch_only();
        int cyc;
        instr_address = 32'h4;
        data_read = 1'b0;
        data_write = 1'b0;
        active = 1'b1;
        apply_reset();
        tick();
        n_checks++; if (m_rd[0] !== 1'b1) begin n_fail++; $display("FAIL fetch_strobe got %0b exp 1", m_rd[0]); end
        n_checks++; if (m_addr[0] !== 32'h4) begin n_fail++; $display("FAIL fetch_address got %h exp 00000004", m_addr[0]); end
        tick();
        n_checks++; if (m_rd[0] !== 1'b0 || m_addr[0] !== 32'h0) begin n_fail++; $display("FAIL fwait_idle got rd=%0b addr=%h exp rd=0 addr=0", m_rd[0], m_addr[0]); end
        tick();
        n_checks++; if (cpu_en[0] !== 1'b1) begin n_fail++; $display("FAIL first_pulse got %0b exp 1", cpu_en[0]); end
        n_checks++; if (instr_rd[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL fetch_word got %h exp 12345678", instr_rd[0]); end
        n_checks++; if (stall[0] !== 32'(PERF * 2)) begin n_fail++; $display("FAIL stall_first got %0d exp %0d", stall[0], PERF * 2); end
        wait_pulse(0, 20, cyc);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL fetch_period1 got %0d exp 3", cyc); end
        n_checks++; if (stall[0] !== 32'(PERF * 4)) begin n_fail++; $display("FAIL stall_second got %0d exp %0d", stall[0], PERF * 4); end
        wait_pulse(0, 20, cyc);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL fetch_period2 got %0d exp 3", cyc); end
        n_checks++; if (data_rd[0] !== 32'h0) begin n_fail++; $display("FAIL fetch_data_kept got %h exp 0", data_rd[0]); end
    endtask

    task automatic test_write();
        int cyc;
        int nwr;
        data_write = 1'b1;
        data_address = 32'hFFFF_0004;
        data_writedata = 32'hDEAD_BEEF;
        apply_reset();
        tick();
        tick();
        tick();
        n_checks++; if (m_wr[0] !== 1'b1 || m_rd[0] !== 1'b0) begin n_fail++; $display("FAIL write_strobe got wr=%0b rd=%0b exp wr=1 rd=0", m_wr[0], m_rd[0]); end
        n_checks++; if (m_addr[0] !== 32'hFFFF_0004) begin n_fail++; $display("FAIL write_address got %h exp ffff0004", m_addr[0]); end
        n_checks++; if (m_wdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_data got %h exp deadbeef", m_wdata[0]); end
        tick();
        n_checks++; if (cpu_en[0] !== 1'b1 || m_wr[0] !== 1'b0 || m_wdata[0] !== 32'h0) begin n_fail++; $display("FAIL write_enable got en=%0b wr=%0b wd=%h exp en=1 wr=0 wd=0", cpu_en[0], m_wr[0], m_wdata[0]); end
        cyc = 0;
        nwr = 0;
        do begin
            tick();
            cyc++;
            nwr += int'(m_wr[0]);
        end while (!cpu_en[0] && cyc < 20);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL write_period got %0d exp 4", cyc); end
        n_checks++; if (nwr !== 1) begin n_fail++; $display("FAIL write_count got %0d exp 1", nwr); end
    endtask

    task automatic test_read_l3();
        int cyc;
        int nrd;
        int b2b;
        logic prev;
        data_write = 1'b0;
        data_read = 1'b1;
        data_address = 32'hFFFF_0008;
        instr_address = 32'h4;
        apply_reset();
        b2b = 0;
        prev = 1'b0;
        for (int step = 0; step < 2; step++) begin
            cyc = 0;
            nrd = 0;
            do begin
                tick();
                cyc++;
                if (m_rd[1] && prev) b2b++;
                prev = m_rd[1];
                nrd += int'(m_rd[1]);
            end while (!cpu_en[1] && cyc < 40);
            n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL read_period step%0d got %0d exp 9", step, cyc); end
            n_checks++; if (nrd !== 2) begin n_fail++; $display("FAIL read_strobes step%0d got %0d exp 2", step, nrd); end
            n_checks++; if (data_rd[1] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL read_word step%0d got %h exp cafef00d", step, data_rd[1]); end
        end
        n_checks++; if (instr_rd[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL read_fetch_word got %h exp 12345678", instr_rd[1]); end
        n_checks++; if (b2b !== 0) begin n_fail++; $display("FAIL read_back_to_back got %0d exp 0", b2b); end
    endtask

    task automatic test_both();
        int cyc;
        int nrd;
        int nwr;
        logic [31:0] wa;
        logic [31:0] wd;
        data_read = 1'b1;
        data_write = 1'b0;
        data_address = 32'hFFFF_0008;
        apply_reset();
        wait_pulse(0, 20, cyc);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL read_l1_period got %0d exp 5", cyc); end
        n_checks++; if (data_rd[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL read_l1_word got %h exp cafef00d", data_rd[0]); end
        data_write = 1'b1;
        data_writedata = 32'h1111_2222;
        cyc = 0;
        nrd = 0;
        nwr = 0;
        wa = 32'h0;
        wd = 32'h0;
        do begin
            tick();
            cyc++;
            nrd += int'(m_rd[0]);
            nwr += int'(m_wr[0]);
            if (m_wr[0]) begin
                wa = m_addr[0];
                wd = m_wdata[0];
            end
        end while (!cpu_en[0] && cyc < 20);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL both_period got %0d exp 4", cyc); end
        n_checks++; if (nrd !== 1 || nwr !== 1) begin n_fail++; $display("FAIL both_strobes got rd=%0d wr=%0d exp rd=1 wr=1", nrd, nwr); end
        n_checks++; if (wa !== 32'hFFFF_0008 || wd !== 32'h1111_2222) begin n_fail++; $display("FAIL both_write got a=%h d=%h exp a=ffff0008 d=11112222", wa, wd); end
        n_checks++; if (data_rd[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL both_data_kept got %h exp cafef00d", data_rd[0]); end
    endtask

    task automatic test_halt();
        int act;
        data_read = 1'b0;
        data_write = 1'b0;
        active = 1'b1;
        apply_reset();
        tick();
        tick();
        active = 1'b0;
        tick();
        n_checks++; if (cpu_en[0] !== 1'b1) begin n_fail++; $display("FAIL halt_last_pulse got %0b exp 1", cpu_en[0]); end
        for (int phase = 0; phase < 2; phase++) begin
            act = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                act += int'(m_rd[0]) + int'(m_wr[0]) + int'(cpu_en[0]);
            end
            n_checks++; if (act !== 0) begin n_fail++; $display("FAIL halt_activity phase%0d got %0d exp 0", phase, act); end
            n_checks++; if (dbg[0] !== HALT) begin n_fail++; $display("FAIL halt_state phase%0d got %0d exp %0d", phase, dbg[0], HALT); end
            active = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int nrd;
        logic [31:0] first_addr;
        data_read = 1'b1;
        data_write = 1'b0;
        data_address = 32'hFFFF_0008;
        active = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (dbg[0] !== DWAIT) begin n_fail++; $display("FAIL mid_state got %0d exp %0d", dbg[0], DWAIT); end
        reset = 1'b0;
        #1;
        n_checks++; if (cpu_en[0] !== 1'b0 || m_rd[0] !== 1'b0 || m_wr[0] !== 1'b0) begin n_fail++; $display("FAIL mid_strobes got en=%0b rd=%0b wr=%0b exp 0 0 0", cpu_en[0], m_rd[0], m_wr[0]); end
        n_checks++; if (m_addr[0] !== 32'h0 || m_wdata[0] !== 32'h0) begin n_fail++; $display("FAIL mid_bus got a=%h d=%h exp 0 0", m_addr[0], m_wdata[0]); end
        n_checks++; if (instr_rd[0] !== 32'h0 || data_rd[0] !== 32'h0) begin n_fail++; $display("FAIL mid_readdata got i=%h d=%h exp 0 0", instr_rd[0], data_rd[0]); end
        n_checks++; if (stall[0] !== 32'h0) begin n_fail++; $display("FAIL mid_stall got %0d exp 0", stall[0]); end
        data_read = 1'b0;
        tick();
        reset = 1'b1;
        cyc = 0;
        nrd = 0;
        first_addr = 32'hFFFF_FFFF;
        do begin
            tick();
            cyc++;
            if (m_rd[0] && nrd == 0) first_addr = m_addr[0];
            nrd += int'(m_rd[0]);
        end while (!cpu_en[0] && cyc < 20);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL post_reset_period got %0d exp 3", cyc); end
        n_checks++; if (nrd !== 1 || first_addr !== 32'h4) begin n_fail++; $display("FAIL post_reset_access got n=%0d a=%h exp n=1 a=00000004", nrd, first_addr); end
        n_checks++; if (stall[0] !== 32'(PERF * 2)) begin n_fail++; $display("FAIL post_reset_stall got %0d exp %0d", stall[0], PERF * 2); end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_write();
        test_read_l3();
        test_both();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
